// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   - alu_op_t   : ALU operation encoding (ID/EX aluOp field)
//   - FW_*       : forwarding-mux select values
//   - ex_state_t : EX stage sequencing states
package pipeline_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_MUL = 3'd6,
        ALU_RSV = 3'd7      // reserved, executes as ADD
    } alu_op_t;

    // Select value 3 is unused and falls back to the ID/EX operand.
    localparam logic [1:0] FW_ID    = 2'd0;
    localparam logic [1:0] FW_WB    = 2'd1;
    localparam logic [1:0] FW_EXMEM = 2'd2;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ex_state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : latch a/b and begin (ignored while busy)
//   abort      : drop the operation in progress
//   a, b       : operands
//   busy       : operation in progress
//   done       : high in the cycle of the final iteration
//   product    : low DATA_W bits of a*b, valid while done is high
module seq_mul #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic              busy_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] mcand_reg;   // shifts left; bits above DATA_W are never needed
    logic [DATA_W-1:0] mplier_reg;  // shifts right; bit 0 gates the partial product
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // The product is taken from acc_next so the last iteration and the
    // hand-off to the pipeline happen in the same cycle.
    assign busy    = busy_reg;
    assign done    = busy_reg && (count_reg == LAST);
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            count_reg  <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else if (abort) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
        end else if (start && !busy_reg) begin
            busy_reg   <= 1'b1;
            count_reg  <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
            if (count_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL with
// pipeline stall, and the EX/MEM pipeline register.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   id_*                      : ID/EX instruction fields and operands
//   frwrdA, frwrdB            : forwarding selects for rs / rt
//   wb_data                   : MEM/WB write-back value (forward source)
//   flush                     : kill the instruction currently in EX
//   stall                     : hold PC, IF/ID and ID/EX
//   exmem_*                   : EX/MEM pipeline register outputs
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_aluSrc,
    input  logic [2:0]        id_aluOp,
    input  logic [DATA_W-1:0] id_rsData,
    input  logic [DATA_W-1:0] id_rtData,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rd,
    input  logic [1:0]        frwrdA,
    input  logic [1:0]        frwrdB,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              exmem_valid,
    output logic              exmem_regWrite,
    output logic              exmem_memRead,
    output logic              exmem_memWrite,
    output logic [DATA_W-1:0] exmem_aluRes,
    output logic [DATA_W-1:0] exmem_storeData,
    output logic [4:0]        exmem_rd
);

    ex_state_t         state_reg;
    logic              exmem_valid_reg;
    logic              exmem_regwrite_reg;
    logic              exmem_memread_reg;
    logic              exmem_memwrite_reg;
    logic [DATA_W-1:0] exmem_alures_reg;
    logic [DATA_W-1:0] exmem_store_reg;
    logic [4:0]        exmem_rd_reg;

    // Control of the MUL in flight, captured at issue because ID/EX is
    // free to change once the multiplier owns the stage.
    logic              mul_regwrite_reg;
    logic              mul_memread_reg;
    logic              mul_memwrite_reg;
    logic [4:0]        mul_rd_reg;
    logic [DATA_W-1:0] mul_store_reg;

    alu_op_t           alu_op;
    logic [DATA_W-1:0] fw_id [2];
    logic [1:0]        fw_sel [2];
    logic [DATA_W-1:0] fw_data [2];
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              mul_issue;
    logic              mul_abort;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign alu_op = alu_op_t'(id_aluOp);

    // Forwarding muxes: index 0 is operand A (rs), index 1 is operand B (rt).
    assign fw_id[0]  = id_rsData;
    assign fw_id[1]  = id_rtData;
    assign fw_sel[0] = frwrdA;
    assign fw_sel[1] = frwrdB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fw_data[gi] = (fw_sel[gi] == FW_WB)    ? wb_data :
                                 (fw_sel[gi] == FW_EXMEM) ? exmem_alures_reg :
                                                            fw_id[gi];
        end
    endgenerate

    assign opnd_a = fw_data[0];
    assign fwd_b  = fw_data[1];
    assign alu_b  = id_aluSrc ? id_imm : fwd_b;

    always_comb begin
        alu_res = opnd_a + alu_b;
        case (alu_op)
            ALU_SUB: alu_res = opnd_a - alu_b;
            ALU_AND: alu_res = opnd_a & alu_b;
            ALU_OR:  alu_res = opnd_a | alu_b;
            ALU_XOR: alu_res = opnd_a ^ alu_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(opnd_a) < $signed(alu_b))};
            default: alu_res = opnd_a + alu_b;
        endcase
    end

    // Flush outranks a MUL issue; a flush during MUL_BUSY releases the stall
    // in the same cycle so the front end can refetch.
    assign mul_issue = (state_reg == IDLE) && id_valid && (alu_op == ALU_MUL) && !flush;
    assign mul_abort = (state_reg == MUL_BUSY) && flush;
    assign stall     = !rst && (mul_issue ||
                       ((state_reg == MUL_BUSY) && mul_busy && !flush && !mul_done));

    seq_mul #(
        .DATA_W (DATA_W)
    ) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_issue),
        .abort   (mul_abort),
        .a       (opnd_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            exmem_valid_reg    <= 1'b0;
            exmem_regwrite_reg <= 1'b0;
            exmem_memread_reg  <= 1'b0;
            exmem_memwrite_reg <= 1'b0;
            exmem_alures_reg   <= '0;
            exmem_store_reg    <= '0;
            exmem_rd_reg       <= '0;
            mul_regwrite_reg   <= 1'b0;
            mul_memread_reg    <= 1'b0;
            mul_memwrite_reg   <= 1'b0;
            mul_rd_reg         <= '0;
            mul_store_reg      <= '0;
        end else begin
            // Bubble unless an instruction retires below; data fields hold.
            exmem_valid_reg    <= 1'b0;
            exmem_regwrite_reg <= 1'b0;
            exmem_memread_reg  <= 1'b0;
            exmem_memwrite_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (id_valid && !flush) begin
                        if (alu_op == ALU_MUL) begin
                            state_reg        <= MUL_BUSY;
                            mul_regwrite_reg <= id_regWrite;
                            mul_memread_reg  <= id_memRead;
                            mul_memwrite_reg <= id_memWrite;
                            mul_rd_reg       <= id_rd;
                            mul_store_reg    <= fwd_b;
                        end else begin
                            exmem_valid_reg    <= 1'b1;
                            exmem_regwrite_reg <= id_regWrite;
                            exmem_memread_reg  <= id_memRead;
                            exmem_memwrite_reg <= id_memWrite;
                            exmem_alures_reg   <= alu_res;
                            exmem_store_reg    <= fwd_b;
                            exmem_rd_reg       <= id_rd;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else if (mul_done) begin
                        state_reg          <= IDLE;
                        exmem_valid_reg    <= 1'b1;
                        exmem_regwrite_reg <= mul_regwrite_reg;
                        exmem_memread_reg  <= mul_memread_reg;
                        exmem_memwrite_reg <= mul_memwrite_reg;
                        exmem_alures_reg   <= mul_product;
                        exmem_store_reg    <= mul_store_reg;
                        exmem_rd_reg       <= mul_rd_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign exmem_valid     = exmem_valid_reg;
    assign exmem_regWrite  = exmem_regwrite_reg;
    assign exmem_memRead   = exmem_memread_reg;
    assign exmem_memWrite  = exmem_memwrite_reg;
    assign exmem_aluRes    = exmem_alures_reg;
    assign exmem_storeData = exmem_store_reg;
    assign exmem_rd        = exmem_rd_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage. Expected results are pushed into a
// scoreboard queue as instructions are driven and popped by a monitor
// whenever EX/MEM presents a valid entry.
module tb_ex_stage;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_regWrite, id_memRead, id_memWrite, id_aluSrc;
    logic [2:0]  id_aluOp;
    logic [31:0] id_rsData, id_rtData, id_imm;
    logic [4:0]  id_rd;
    logic [1:0]  frwrdA, frwrdB;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall;
    logic        exmem_valid, exmem_regWrite, exmem_memRead, exmem_memWrite;
    logic [31:0] exmem_aluRes, exmem_storeData;
    logic [4:0]  exmem_rd;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_res;     // expected current exmem_aluRes
    int          checks = 0;
    int          fails  = 0;
    logic        mon_en = 1'b0;

    ex_stage #(.DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_regWrite     (id_regWrite),
        .id_memRead      (id_memRead),
        .id_memWrite     (id_memWrite),
        .id_aluSrc       (id_aluSrc),
        .id_aluOp        (id_aluOp),
        .id_rsData       (id_rsData),
        .id_rtData       (id_rtData),
        .id_imm          (id_imm),
        .id_rd           (id_rd),
        .frwrdA          (frwrdA),
        .frwrdB          (frwrdB),
        .wb_data         (wb_data),
        .flush           (flush),
        .stall           (stall),
        .exmem_valid     (exmem_valid),
        .exmem_regWrite  (exmem_regWrite),
        .exmem_memRead   (exmem_memRead),
        .exmem_memWrite  (exmem_memWrite),
        .exmem_aluRes    (exmem_aluRes),
        .exmem_storeData (exmem_storeData),
        .exmem_rd        (exmem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        case (op)
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return a + b;
        endcase
    endfunction

    // Monitor: every valid EX/MEM entry must match the oldest expectation;
    // with nothing outstanding, EX/MEM must hold a bubble.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("no_result_valid", {63'd0, exmem_valid}, 64'd0);
            end else if (exmem_valid === 1'b1) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_aluRes", {32'd0, exmem_aluRes}, {32'd0, e.res});
                chk("result_ctrl",
                    {24'd0, exmem_storeData, exmem_rd, exmem_regWrite, exmem_memRead, exmem_memWrite},
                    {24'd0, e.sd, e.rd, e.rw, e.mr, e.mw});
                $display("result rd=%0d aluRes=%0h storeData=%0h", exmem_rd, exmem_aluRes, exmem_storeData);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_regWrite = 1'b0;
        id_memRead  = 1'b0;
        id_memWrite = 1'b0;
        id_aluSrc   = 1'b0;
        id_aluOp    = OP_ADD;
        id_rsData   = '0;
        id_rtData   = '0;
        id_imm      = '0;
        id_rd       = '0;
        frwrdA      = 2'd0;
        frwrdB      = 2'd0;
        flush       = 1'b0;
    endtask

    // Drive one instruction into EX; push its expected EX/MEM entry when it
    // is expected to retire.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb,
                         input logic rw, input logic mr, input logic mw, input logic fl,
                         input logic expect_result);
        logic [31:0] a_e, bf_e, b_e;
        exp_t e;
        id_valid = 1'b1; id_aluOp = op; id_rsData = rs; id_rtData = rt; id_imm = imm;
        id_aluSrc = src; id_rd = rd; frwrdA = fa; frwrdB = fb; wb_data = wb;
        id_regWrite = rw; id_memRead = mr; id_memWrite = mw; flush = fl;
        a_e  = (fa == 2'd1) ? wb : (fa == 2'd2) ? last_res : rs;
        bf_e = (fb == 2'd1) ? wb : (fb == 2'd2) ? last_res : rt;
        b_e  = src ? imm : bf_e;
        $display("issue op=%0d a=%0h b=%0h rd=%0d flush=%0b", op, a_e, b_e, rd, fl);
        if (expect_result) begin
            e.res = model(op, a_e, b_e);
            e.sd = bf_e; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
            exp_q.push_back(e);
            last_res = e.res;
        end
    endtask

    // Inputs the stage must ignore while the multiplier owns it.
    task automatic garble();
        id_valid  = 1'b1;
        id_aluOp  = OP_ADD;
        id_rsData = $urandom;
        id_rtData = $urandom;
        id_rd     = 5'($urandom_range(0, 31));
        frwrdA    = 2'd1;
        frwrdB    = 2'd1;
        wb_data   = ~wb_data;
    endtask

    // MUL from issue to completion, or interrupted by flush/rst at the given
    // counter value (-1 = never). Ends one cycle after the last check, #1
    // past the edge, ready for the next instruction.
    task automatic run_mul(input logic [31:0] rs, input logic [31:0] rt, input logic [1:0] fb,
                           input logic [31:0] wb, input logic [4:0] rd,
                           input int abort_at, input int rst_at);
        issue(OP_MUL, rs, rt, 32'd0, 1'b0, rd, 2'd0, fb, wb, 1'b1, 1'b0, 1'b0, 1'b0,
              (abort_at < 0) && (rst_at < 0));
        @(negedge clk);
        chk("mul_issue_stall", {63'd0, stall}, 64'd1);
        for (int c = 0; c < 32; c++) begin
            tick();
            garble();
            if (c == abort_at) flush = 1'b1;
            if (c == rst_at)   rst   = 1'b1;
            @(negedge clk);
            chk("mul_bubble_valid", {63'd0, exmem_valid}, 64'd0);
            if (c == abort_at || c == rst_at) begin
                chk("mul_interrupt_stall", {63'd0, stall}, 64'd0);
                tick();
                rst = 1'b0;
                idle();
                if (c == rst_at) last_res = '0;
                @(negedge clk);
                chk("post_interrupt_stall", {63'd0, stall}, 64'd0);
                chk("post_interrupt_valid", {63'd0, exmem_valid}, 64'd0);
                chk("post_interrupt_aluRes", {32'd0, exmem_aluRes}, {32'd0, last_res});
                if (c == rst_at) begin
                    chk("post_rst_ctrl",
                        {24'd0, exmem_storeData, exmem_rd, exmem_regWrite, exmem_memRead, exmem_memWrite},
                        64'd0);
                end
                tick();
                return;
            end
            chk("mul_busy_stall", {63'd0, stall}, (c != 31) ? 64'd1 : 64'd0);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        wb_data  = '0;
        last_res = '0;
        // A MUL presented during reset must not raise stall.
        id_valid = 1'b1;
        id_aluOp = OP_MUL;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_valid_ctrl", {60'd0, exmem_valid, exmem_regWrite, exmem_memRead, exmem_memWrite}, 64'd0);
        chk("rst_data", {exmem_aluRes, exmem_storeData}, 64'd0);
        chk("rst_rd", {59'd0, exmem_rd}, 64'd0);
        tick();
        rst = 1'b0;
        idle();
        mon_en = 1'b1;

        // ADD 5+7 -> 12, no stall
        issue(OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("add_stall", {63'd0, stall}, 64'd0);
        tick();
        // 15+5 = 20 feeds the SUB below through the EX/MEM forward path
        issue(OP_ADD, 32'd15, 32'd5, 32'd0, 1'b0, 5'd4, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_SUB, 32'd100, 32'd200, 32'd0, 1'b0, 5'd5, 2'd2, 2'd1, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd7, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 5'd8, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_OR, 32'hF000_0001, 32'h0000_1230, 32'd0, 1'b0, 5'd9, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b0, 5'd10, 2'd3, 2'd3, 32'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        // Immediate path: store data still the forwarded rt, never imm
        issue(OP_ADD, 32'd10, 32'h55, 32'hFFFF_FFFC, 1'b1, 5'd11, 2'd0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        issue(OP_RSV, 32'd3, 32'd4, 32'd0, 1'b0, 5'd12, 2'd0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        issue(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd13, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();                                  // id_valid=0 -> bubble
        tick();
        issue(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd14, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_idle_stall", {63'd0, stall}, 64'd0);
        tick();
        // After two bubbles EX/MEM data must still hold the SLT result
        issue(OP_ADD, 32'd0, 32'd9, 32'd0, 1'b0, 5'd15, 2'd2, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tick();

        // MUL 6x7, then an ADD that must enter right after completion
        run_mul(32'd6, 32'd7, 2'd0, 32'h1234_5678, 5'd20, -1, -1);
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd21, 2'd2, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tick();

        // MUL 0xFFFFFFFF x 2 with B forwarded from MEM/WB
        run_mul(32'hFFFF_FFFF, 32'd999, 2'd1, 32'd2, 5'd22, -1, -1);
        idle();
        tick();

        // MUL issue with flush in IDLE must not start
        issue(OP_MUL, 32'd3, 32'd3, 32'd0, 1'b0, 5'd23, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_mul_issue_stall", {63'd0, stall}, 64'd0);
        tick();
        idle();
        @(negedge clk);
        chk("flush_mul_idle_stall", {63'd0, stall}, 64'd0);
        tick();

        // Flush at counter=10: bubble, back to IDLE, no result
        run_mul(32'd9, 32'd9, 2'd0, 32'd0, 5'd24, 10, -1);
        issue(OP_ADD, 32'd40, 32'd2, 32'd0, 1'b0, 5'd25, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset at counter=5: outputs cleared, then a normal ADD
        run_mul(32'd11, 32'd13, 2'd0, 32'd0, 5'd26, -1, 5);
        issue(OP_ADD, 32'd8, 32'd8, 32'd0, 1'b0, 5'd27, 2'd2, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        repeat (3) tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; MUL iteration count equals DATA_W.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_valid, id_regWrite, id_memRead, id_memWrite, id_aluSrc  in  1 each  ID/EX control.
REQ-005 id_aluOp  in  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, MUL=6; 7 reserved, treated as ADD.
REQ-006 id_rsData, id_rtData, id_imm  in  DATA_W each  register-file operands and sign-extended immediate.
REQ-007 id_rd  in  5  destination register.
REQ-008 frwrdA, frwrdB  in  2  forward selects: 0=ID/EX data, 1=wb_data (MEM/WB), 2=exmem_aluRes (EX/MEM), 3=ID/EX data.
REQ-009 wb_data  in  DATA_W  MEM/WB write-back value.
REQ-010 flush  in  1  kills the instruction currently in EX.
REQ-011 stall  out  1  holds PC, IF/ID and ID/EX while high.
REQ-012 exmem_valid, exmem_regWrite, exmem_memRead, exmem_memWrite  out  1 each  registered EX/MEM control.
REQ-013 exmem_aluRes, exmem_storeData  out  DATA_W  registered result and forwarded rt value.
REQ-014 exmem_rd  out  5  registered destination; exmem_rd and exmem_regWrite drive the forwarding unit's EX inputs.

Function
REQ-015 Operand A = mux(frwrdA); forwarded B = mux(frwrdB); ALU B = id_imm when id_aluSrc else forwarded B.
REQ-016 Single-cycle ops: result registered into EX/MEM on the next edge; latency 1 cycle; stall stays low.
REQ-017 ADD/SUB wrap modulo 2^DATA_W; SLT is signed and yields 1 or 0; MUL yields the low DATA_W bits of the unsigned product.
REQ-018 exmem_storeData is always forwarded B, never id_imm.
REQ-019 FSM states: IDLE, MUL_BUSY.
REQ-020 IDLE->MUL_BUSY when id_valid and id_aluOp=MUL and no flush; forwarded A and B latched into the multiplier, counter cleared to 0.
REQ-021 stall = (IDLE and id_valid and aluOp=MUL and no flush) or (MUL_BUSY and counter != DATA_W-1).
REQ-022 MUL_BUSY: one shift-add iteration per cycle, counter increments; at counter=DATA_W-1 the product and latched control go to EX/MEM, then MUL_BUSY->IDLE.
REQ-023 MUL timing: issue cycle T; stall high T..T+DATA_W-1; result in EX/MEM after edge T+DATA_W; next instruction enters EX at T+DATA_W+1.
REQ-024 Every cycle the block is stalled, EX/MEM loads a bubble (valid, regWrite, memRead, memWrite = 0; data unchanged).
REQ-025 In MUL_BUSY, ID/EX inputs, frwrdA/B and wb_data are ignored; latched operands only.
REQ-026 flush in IDLE: EX/MEM loads a bubble and no MUL starts; flush wins over MUL issue.
REQ-027 flush in MUL_BUSY: multiply aborts, EX/MEM loads a bubble, state->IDLE, stall low in that cycle.
REQ-028 id_valid=0: EX/MEM loads a bubble.

Reset
REQ-029 On rst high at a clock edge: state IDLE, counter 0, every exmem_* output 0, multiplier registers 0.
REQ-030 stall reads 0 in any cycle with rst high; rst overrides flush and any in-progress MUL.

Structure
REQ-031 Shared package pipeline_pkg holds the aluOp encoding, forward-select constants (FW_ID, FW_WB, FW_EXMEM) and the ex FSM state enum.
REQ-032 The iterative multiplier is sub-module seq_mul (start, operands in; busy, done, product out); all else in ex_stage.

Verification
REQ-033 ADD rs=5, rt=7, frwrd 0/0 -> exmem_aluRes=12 after 1 edge, stall never high.
REQ-034 SUB, frwrdA=2 with exmem_aluRes=20, frwrdB=1 with wb_data=3 -> next exmem_aluRes=17.
REQ-035 SLT A=0xFFFFFFFF, B=1 -> 1; ADD 0xFFFFFFFF+1 -> 0, wrap.
REQ-036 MUL 6x7 at T -> stall high 32 cycles, 32 bubbles, exmem_aluRes=42 with valid=1 after edge T+32; wb_data toggled mid-op has no effect.
REQ-037 MUL 0xFFFF_FFFF x 2 -> 0xFFFF_FFFE; flush at counter=10 -> bubble, IDLE, stall low, no result.
REQ-038 rst asserted at counter=5 -> next cycle all outputs 0, IDLE; following ADD completes normally.
